// File: rtl/stream_mux_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stream_mux_arb : registered M-to-1 stream mux, sel or round-robin grant held per packet.
// Optional STREAM_MUX_BEAT_CNT_EN adds a saturating output beat counter.  Rev 1.0
// ---------------------------------------------------------------------------
module stream_mux_arb #(
  parameter int NUM_OF_INPUTS = 5,
  parameter int INPUT_WIDTH   = 4,
  parameter int ARB_MODE      = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [INPUT_WIDTH-1:0]           in_data [NUM_OF_INPUTS-1:0],
  input  logic [NUM_OF_INPUTS-1:0]         in_valid,
  input  logic [NUM_OF_INPUTS-1:0]         in_last,
  output logic [NUM_OF_INPUTS-1:0]         in_ready,
  input  logic [$clog2(NUM_OF_INPUTS)-1:0] sel,
  output logic [INPUT_WIDTH-1:0]           out_data,
  output logic                             out_valid,
  output logic                             out_last,
  output logic [$clog2(NUM_OF_INPUTS)-1:0] out_chan,
`ifdef STREAM_MUX_BEAT_CNT_EN
  input  logic                             cnt_clr,
  output logic [15:0]                      beat_cnt,
`endif
  input  logic                             out_ready
);

  localparam int SW = $clog2(NUM_OF_INPUTS);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]             state;
  logic [SW-1:0]          rr_ptr;
  logic [SW-1:0]          lock_chan;
  logic [SW-1:0]          rr_grant;
  logic                   rr_found;
  logic [SW-1:0]          grant;
  logic                   grant_vld;
  logic                   sel_valid;
  logic                   lock_valid;
  logic [INPUT_WIDTH-1:0] data_sel;
  logic                   last_sel;
  logic                   load_en;
  logic                   in_fire;

  // Search starts one past the last served channel so every requester gets a turn.
  always_comb begin
    rr_grant = '0;
    rr_found = 1'b0;
    for (int k = 1; k <= NUM_OF_INPUTS; k++) begin
      if (!rr_found && in_valid[(int'(rr_ptr) + k) % NUM_OF_INPUTS]) begin
        rr_grant = SW'((int'(rr_ptr) + k) % NUM_OF_INPUTS);
        rr_found = 1'b1;
      end
    end
  end

  // Out-of-range sel matches no channel, so it simply never grants.
  always_comb begin
    sel_valid  = 1'b0;
    lock_valid = 1'b0;
    data_sel   = '0;
    last_sel   = 1'b0;
    for (int i = 0; i < NUM_OF_INPUTS; i++) begin
      if (sel == SW'(i))       sel_valid  = in_valid[i];
      if (lock_chan == SW'(i)) lock_valid = in_valid[i];
      if (grant == SW'(i)) begin
        data_sel = in_data[i];
        last_sel = in_last[i];
      end
    end
  end

  always_comb begin
    grant     = lock_chan;
    grant_vld = lock_valid;
    if (state == IDLE) begin
      if (ARB_MODE == 0) begin
        grant     = sel;
        grant_vld = sel_valid;
      end else begin
        grant     = rr_grant;
        grant_vld = rr_found;
      end
    end
  end

  assign load_en = !out_valid || out_ready;
  assign in_fire = grant_vld && load_en && !rst;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_OF_INPUTS; i++) begin
      in_ready[i] = in_fire && (grant == SW'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_chan  <= '0;
      state     <= IDLE;
      lock_chan <= '0;
      rr_ptr    <= SW'(NUM_OF_INPUTS - 1);
    end else begin
      if (load_en) begin
        out_valid <= in_fire;
        if (in_fire) begin
          out_data <= data_sel;
          out_last <= last_sel;
          out_chan <= grant;
        end
      end
      if (in_fire) begin
        if (state == IDLE) begin
          if (last_sel) begin
            rr_ptr <= grant;
          end else begin
            state     <= LOCKED;
            lock_chan <= grant;
          end
        end else if (last_sel) begin
          state  <= IDLE;
          rr_ptr <= lock_chan;
        end
      end
    end
  end

`ifdef STREAM_MUX_BEAT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (cnt_clr) begin
      beat_cnt <= '0;
    end else if (out_valid && out_ready && beat_cnt != 16'hFFFF) begin
      beat_cnt <= beat_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_arb.sv
`default_nettype none
// tb_stream_mux_arb : directed checks of stream_mux_arb in round-robin and external-select modes.
module tb_stream_mux_arb;
  localparam int N  = 5;
  localparam int W  = 4;
  localparam int SW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data [N-1:0];
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_last;
  logic [SW-1:0] sel;
  logic          out_ready;
  logic          cnt_clr;

  logic [N-1:0]  rr_in_ready, sl_in_ready;
  logic [W-1:0]  rr_out_data, sl_out_data;
  logic          rr_out_valid, sl_out_valid;
  logic          rr_out_last, sl_out_last;
  logic [SW-1:0] rr_out_chan, sl_out_chan;
`ifdef STREAM_MUX_BEAT_CNT_EN
  logic [15:0]   rr_beat_cnt, sl_beat_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_mux_arb #(.NUM_OF_INPUTS(N), .INPUT_WIDTH(W), .ARB_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(rr_in_ready), .sel(sel), .out_data(rr_out_data), .out_valid(rr_out_valid),
    .out_last(rr_out_last), .out_chan(rr_out_chan),
`ifdef STREAM_MUX_BEAT_CNT_EN
    .cnt_clr(cnt_clr), .beat_cnt(rr_beat_cnt),
`endif
    .out_ready(out_ready)
  );

  stream_mux_arb #(.NUM_OF_INPUTS(N), .INPUT_WIDTH(W), .ARB_MODE(0)) u_sel (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(sl_in_ready), .sel(sel), .out_data(sl_out_data), .out_valid(sl_out_valid),
    .out_last(sl_out_last), .out_chan(sl_out_chan),
`ifdef STREAM_MUX_BEAT_CNT_EN
    .cnt_clr(cnt_clr), .beat_cnt(sl_beat_cnt),
`endif
    .out_ready(out_ready)
  );

  task automatic hold_reset();
    rst = 1'b1; in_valid = '0; in_last = '0; out_ready = 1'b1; sel = '0; cnt_clr = 1'b0;
    for (int i = 0; i < N; i++) in_data[i] = '0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    hold_reset();
    in_valid = '1; in_last = '1;
    #1;
    checks++; if (rr_in_ready !== 5'b0) begin errors++; $display("FAIL reset_rr_in_ready: got %b expected 00000", rr_in_ready); end
    checks++; if (sl_in_ready !== 5'b0) begin errors++; $display("FAIL reset_sl_in_ready: got %b expected 00000", sl_in_ready); end
    tick();
    checks++; if (rr_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", rr_out_valid); end
    checks++; if (rr_out_data !== 4'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", rr_out_data); end
    checks++; if (rr_out_chan !== 3'd0 || rr_out_last !== 1'b0) begin errors++; $display("FAIL reset_chan_last: got %0d/%b expected 0/0", rr_out_chan, rr_out_last); end
  endtask

  task automatic test_rr_single();
    hold_reset();
    in_valid = '1; in_last = '1;
    for (int i = 0; i < N; i++) in_data[i] = W'(i + 5);
    release_reset();
    checks++; if (rr_out_valid !== 1'b0) begin errors++; $display("FAIL rr_pre_valid: got %b expected 0", rr_out_valid); end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (rr_out_valid !== 1'b1 || rr_out_chan !== SW'(i % N) || rr_out_data !== W'((i % N) + 5)) begin
        errors++;
        $display("FAIL rr_seq[%0d]: got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h",
                 i, rr_out_valid, rr_out_chan, rr_out_data, i % N, (i % N) + 5);
      end
    end
  endtask

  task automatic test_packet();
    hold_reset();
    in_valid = 5'b00010; in_last = 5'b11111; in_data[1] = 4'h1;
    release_reset();
    tick();
    checks++; if (rr_out_chan !== 3'd1) begin errors++; $display("FAIL pkt_prime_chan: got %0d expected 1", rr_out_chan); end
    in_valid = 5'b01101; in_last = 5'b01001;
    in_data[0] = 4'h0; in_data[3] = 4'h3; in_data[2] = 4'hA;
    for (int b = 0; b < 4; b++) begin
      tick();
      checks++;
      if (rr_out_data !== W'(4'hA + b) || rr_out_chan !== 3'd2 || rr_out_last !== (b == 3)) begin
        errors++;
        $display("FAIL pkt_beat[%0d]: got d=%h ch=%0d l=%b expected d=%h ch=2 l=%b",
                 b, rr_out_data, rr_out_chan, rr_out_last, 4'hA + b, b == 3);
      end
      in_data[2] = W'(4'hA + b + 1);
      in_last[2] = (b == 2);
      if (b < 3) begin
        #1;
        checks++; if (rr_in_ready !== 5'b00100) begin errors++; $display("FAIL pkt_in_ready[%0d]: got %b expected 00100", b, rr_in_ready); end
      end
    end
    in_valid[2] = 1'b0;
    tick();
    checks++; if (rr_out_chan !== 3'd3 || rr_out_data !== 4'h3) begin errors++; $display("FAIL pkt_next_ch3: got ch=%0d d=%h expected ch=3 d=3", rr_out_chan, rr_out_data); end
    tick();
    checks++; if (rr_out_chan !== 3'd0 || rr_out_data !== 4'h0) begin errors++; $display("FAIL pkt_next_ch0: got ch=%0d d=%h expected ch=0 d=0", rr_out_chan, rr_out_data); end
  endtask

  task automatic test_stall();
    hold_reset();
    in_valid = 5'b00010; in_last = '0; in_data[1] = 4'h1;
    release_reset();
    tick();
    checks++; if (rr_out_data !== 4'h1) begin errors++; $display("FAIL stall_beat1: got %h expected 1", rr_out_data); end
    in_data[1] = 4'h2;
    tick();
    checks++; if (rr_out_data !== 4'h2) begin errors++; $display("FAIL stall_beat2: got %h expected 2", rr_out_data); end
    out_ready = 1'b0; in_data[1] = 4'h3;
    for (int s = 0; s < 3; s++) begin
      tick();
      checks++;
      if (rr_out_data !== 4'h2 || rr_out_valid !== 1'b1 || rr_in_ready !== 5'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got d=%h v=%b rdy=%b expected d=2 v=1 rdy=00000", s, rr_out_data, rr_out_valid, rr_in_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (rr_in_ready !== 5'b00010) begin errors++; $display("FAIL stall_resume_rdy: got %b expected 00010", rr_in_ready); end
    tick();
    checks++; if (rr_out_data !== 4'h3) begin errors++; $display("FAIL stall_beat3: got %h expected 3", rr_out_data); end
    in_data[1] = 4'h4; in_last[1] = 1'b1;
    tick();
    checks++; if (rr_out_data !== 4'h4 || rr_out_last !== 1'b1) begin errors++; $display("FAIL stall_beat4: got d=%h l=%b expected d=4 l=1", rr_out_data, rr_out_last); end
    in_valid = '0;
    tick();
    checks++; if (rr_out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b expected 0", rr_out_valid); end
  endtask

  task automatic test_sel_lock();
    hold_reset();
    sel = 3'd1; in_valid = 5'b01010; in_last = 5'b01000; in_data[1] = 4'h1; in_data[3] = 4'h9;
    release_reset();
    tick();
    checks++; if (sl_out_data !== 4'h1 || sl_out_chan !== 3'd1 || sl_out_last !== 1'b0) begin errors++; $display("FAIL sel_beat1: got d=%h ch=%0d l=%b expected d=1 ch=1 l=0", sl_out_data, sl_out_chan, sl_out_last); end
    sel = 3'd3; in_data[1] = 4'h2;
    #1;
    checks++; if (sl_in_ready !== 5'b00010) begin errors++; $display("FAIL sel_lock_rdy1: got %b expected 00010", sl_in_ready); end
    tick();
    checks++; if (sl_out_data !== 4'h2 || sl_out_chan !== 3'd1) begin errors++; $display("FAIL sel_beat2: got d=%h ch=%0d expected d=2 ch=1", sl_out_data, sl_out_chan); end
    in_data[1] = 4'h3; in_last[1] = 1'b1;
    #1;
    checks++; if (sl_in_ready !== 5'b00010) begin errors++; $display("FAIL sel_lock_rdy2: got %b expected 00010", sl_in_ready); end
    tick();
    checks++; if (sl_out_data !== 4'h3 || sl_out_chan !== 3'd1 || sl_out_last !== 1'b1) begin errors++; $display("FAIL sel_beat3: got d=%h ch=%0d l=%b expected d=3 ch=1 l=1", sl_out_data, sl_out_chan, sl_out_last); end
    in_valid[1] = 1'b0;
    tick();
    checks++; if (sl_out_chan !== 3'd3 || sl_out_data !== 4'h9) begin errors++; $display("FAIL sel_ch3: got ch=%0d d=%h expected ch=3 d=9", sl_out_chan, sl_out_data); end
    sel = 3'd7;
    #1;
    checks++; if (sl_in_ready !== 5'b0) begin errors++; $display("FAIL sel_oob_rdy: got %b expected 00000", sl_in_ready); end
    tick();
    checks++; if (sl_out_valid !== 1'b0) begin errors++; $display("FAIL sel_oob_valid: got %b expected 0", sl_out_valid); end
  endtask

  task automatic test_reset_mid_packet();
    hold_reset();
    in_valid = 5'b00100; in_last = '0; in_data[2] = 4'h6; out_ready = 1'b0;
    release_reset();
    tick();
    checks++; if (rr_out_valid !== 1'b1 || rr_out_data !== 4'h6 || rr_out_chan !== 3'd2) begin errors++; $display("FAIL mid_loaded: got v=%b d=%h ch=%0d expected v=1 d=6 ch=2", rr_out_valid, rr_out_data, rr_out_chan); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (rr_out_valid !== 1'b0 || rr_out_data !== 4'h0 || rr_out_chan !== 3'd0 || rr_in_ready !== 5'b0) begin errors++; $display("FAIL mid_async_rst: got v=%b d=%h ch=%0d rdy=%b expected all zero", rr_out_valid, rr_out_data, rr_out_chan, rr_in_ready); end
    in_valid = '1; in_last = '1; out_ready = 1'b1;
    for (int i = 0; i < N; i++) in_data[i] = W'(i + 5);
    release_reset();
    tick();
    checks++; if (rr_out_chan !== 3'd0 || rr_out_data !== 4'h5) begin errors++; $display("FAIL mid_restart: got ch=%0d d=%h expected ch=0 d=5", rr_out_chan, rr_out_data); end
  endtask

`ifdef STREAM_MUX_BEAT_CNT_EN
  task automatic test_beat_cnt();
    hold_reset();
    in_valid = '1; in_last = '1;
    release_reset();
    checks++; if (rr_beat_cnt !== 16'd0) begin errors++; $display("FAIL cnt_reset: got %0d expected 0", rr_beat_cnt); end
    repeat (11) tick();
    checks++; if (rr_beat_cnt !== 16'd10) begin errors++; $display("FAIL cnt_ten: got %0d expected 10", rr_beat_cnt); end
    cnt_clr = 1'b1;
    tick();
    checks++; if (rr_beat_cnt !== 16'd0) begin errors++; $display("FAIL cnt_clr: got %0d expected 0", rr_beat_cnt); end
    cnt_clr = 1'b0;
    tick();
    checks++; if (rr_beat_cnt !== 16'd1) begin errors++; $display("FAIL cnt_after_clr: got %0d expected 1", rr_beat_cnt); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rr_single();
    test_packet();
    test_stall();
    test_sel_lock();
    test_reset_mid_packet();
`ifdef STREAM_MUX_BEAT_CNT_EN
    test_beat_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
